// File: rtl/imgproc_pkg.sv
// Shared image-processing definitions: default pixel width, 3x3 window tap
// indices and the bit-slice helper used to pack windows into a flat bus.
package imgproc_pkg;

  localparam int DEFAULT_PIXEL_W = 8;
  localparam int WINDOW_TAPS     = 9;

  localparam int W_TL     = 0;
  localparam int W_TC     = 1;
  localparam int W_TR     = 2;
  localparam int W_ML     = 3;
  localparam int W_CENTRE = 4;
  localparam int W_MR     = 5;
  localparam int W_BL     = 6;
  localparam int W_BC     = 7;
  localparam int W_BR     = 8;

  // LSB position of tap k inside a packed window bus
  function automatic int windowLsb(input int k, input int pixelW);
    return k * pixelW;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: combinational read and registered write at the
// same address, so a same-cycle access returns the previous contents.
module line_buffer
  import imgproc_pkg::*;
#(
  parameter  int DEPTH  = 640,
  parameter  int WIDTH  = DEFAULT_PIXEL_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wrData,
  output logic [WIDTH-1:0]  rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdData = mem[addr];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[addr] <= wrData;
    end
  end

endmodule

// File: rtl/neighbourhood_window.sv
// Streaming 3x3 window generator: two cascaded line buffers feed three
// column shift registers; one registered window per interior pixel.
module neighbourhood_window
  import imgproc_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int PIXEL_W    = DEFAULT_PIXEL_W,
  localparam int COL_W      = $clog2(IMG_WIDTH),
  localparam int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                             writeClk,
  input  logic                             resetN,
  input  logic                             locked,
  input  logic [PIXEL_W-1:0]               pixelIn,
  input  logic                             pixelValid,
  input  logic                             frameStart,
  output logic [WINDOW_TAPS*PIXEL_W-1:0]   windowOut,
  output logic                             windowValid,
  output logic [ROW_W-1:0]                 centreRow,
  output logic [COL_W-1:0]                 centreCol,
  output logic                             frameDone
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(2);
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(2);

  logic [COL_W-1:0] colReg, colNext, curCol;
  logic [ROW_W-1:0] rowReg, rowNext, curRow;
  logic             accept, qualify, lastWindow;
  logic [PIXEL_W-1:0] lineARd, lineBRd;
  logic [PIXEL_W-1:0] colIn   [3];
  logic [PIXEL_W-1:0] histReg [6];
  logic [PIXEL_W-1:0] newWin  [WINDOW_TAPS];
  logic [WINDOW_TAPS*PIXEL_W-1:0] windowNext;

  assign accept = resetN && locked && pixelValid;

  // frameStart overrides the counters so the accepted pixel is (0,0)
  always_comb begin
    curCol  = frameStart ? '0 : colReg;
    curRow  = frameStart ? '0 : rowReg;
    colNext = curCol + 1'b1;
    rowNext = curRow;
    if (curCol == LAST_COL) begin
      colNext = '0;
      rowNext = (curRow == LAST_ROW) ? '0 : curRow + 1'b1;
    end
  end

  assign qualify    = accept && (curRow >= FIRST_ROW) && (curCol >= FIRST_COL);
  assign lastWindow = (curRow == LAST_ROW) && (curCol == LAST_COL);

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) lineA (
    .clk(writeClk), .wrEn(accept), .addr(curCol), .wrData(pixelIn), .rdData(lineARd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) lineB (
    .clk(writeClk), .wrEn(accept), .addr(curCol), .wrData(lineARd), .rdData(lineBRd)
  );

  assign colIn[0] = lineBRd;
  assign colIn[1] = lineARd;
  assign colIn[2] = pixelIn;

  // Each window row is two held pixels plus the incoming right-column pixel
  for (genvar gi = 0; gi < 3; gi++) begin : gRow
    assign newWin[W_TL + gi*3]     = histReg[gi*2];
    assign newWin[W_TL + gi*3 + 1] = histReg[gi*2 + 1];
    assign newWin[W_TL + gi*3 + 2] = colIn[gi];
  end

  for (genvar gi = 0; gi < WINDOW_TAPS; gi++) begin : gPack
    assign windowNext[windowLsb(gi, PIXEL_W) +: PIXEL_W] = newWin[gi];
  end

  always_ff @(posedge writeClk) begin
    if (!resetN) begin
      for (int i = 0; i < 6; i++) histReg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        histReg[i*2]     <= histReg[i*2 + 1];
        histReg[i*2 + 1] <= colIn[i];
      end
    end
  end

  always_ff @(posedge writeClk) begin
    if (!resetN) begin
      colReg      <= '0;
      rowReg      <= '0;
      windowOut   <= '0;
      centreRow   <= '0;
      centreCol   <= '0;
      windowValid <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      windowValid <= 1'b0;
      frameDone   <= 1'b0;
      if (!locked) begin
        colReg <= '0;
        rowReg <= '0;
      end else if (pixelValid) begin
        colReg <= colNext;
        rowReg <= rowNext;
      end
      if (qualify) begin
        windowOut   <= windowNext;
        centreRow   <= curRow - 1'b1;
        centreCol   <= curCol - 1'b1;
        windowValid <= 1'b1;
        frameDone   <= lastWindow;
      end
    end
  end

endmodule

// File: tb/tb_neighbourhood_window.sv
// Scoreboard bench for neighbourhood_window on an 8x6 image with pixel = r*8+c.
module tb_neighbourhood_window;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 8;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic writeClk = 1'b0;
  logic resetN, locked, pixelValid, frameStart;
  logic [PW-1:0]   pixelIn;
  logic [9*PW-1:0] windowOut;
  logic            windowValid, frameDone;
  logic [RW-1:0]   centreRow;
  logic [CW-1:0]   centreCol;

  neighbourhood_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (
    .writeClk(writeClk), .resetN(resetN), .locked(locked), .pixelIn(pixelIn),
    .pixelValid(pixelValid), .frameStart(frameStart), .windowOut(windowOut),
    .windowValid(windowValid), .centreRow(centreRow), .centreCol(centreCol),
    .frameDone(frameDone)
  );

  always #5 writeClk = ~writeClk;

  typedef struct packed {
    logic [9*PW-1:0] win;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic            done;
  } exp_t;

  exp_t expQ[$];
  int vectors = 0;
  int miscompares = 0;
  bit monEn = 0;
  bit expectZero = 0;
  logic [9*PW-1:0] lastWin = '0;
  logic [RW-1:0]   lastRow = '0;
  logic [CW-1:0]   lastCol = '0;

  function automatic logic [9*PW-1:0] expWin(input int R, input int C);
    logic [9*PW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*PW +: PW] = PW'((R-1+i)*W + (C-1+j));
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per windowValid pulse, checks hold otherwise
  always @(negedge writeClk) begin
    if (monEn) begin
      if (expectZero) begin
        check("resetValid", windowValid, 0);
        check("resetWindow", windowOut, 0);
        check("resetRow", centreRow, 0);
        check("resetCol", centreCol, 0);
        check("resetDone", frameDone, 0);
        lastWin = '0; lastRow = '0; lastCol = '0;
        expectZero = 0;
      end else if (windowValid) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpectedWindow: got centre (%0d,%0d) expected no window at %0t",
                   centreRow, centreCol, $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          $display("window centre (%0d,%0d) expected (%0d,%0d) done=%0b", centreRow, centreCol, e.row, e.col, frameDone);
          check("window", windowOut, e.win);
          check("centreRow", centreRow, e.row);
          check("centreCol", centreCol, e.col);
          check("frameDone", frameDone, e.done);
        end
        lastWin = windowOut; lastRow = centreRow; lastCol = centreCol;
      end else begin
        check("holdWindow", windowOut, lastWin);
        check("holdCentre", {centreRow, centreCol}, {lastRow, lastCol});
        check("doneWithoutValid", frameDone, 0);
      end
    end
  end

  task automatic sendPixel(input int r, input int c, input bit fs);
    @(posedge writeClk); #1;
    locked = 1; pixelValid = 1; frameStart = fs; pixelIn = PW'(r*W + c);
    if (r >= 2 && c >= 2)
      expQ.push_back('{win: expWin(r-1, c-1), row: RW'(r-1), col: CW'(c-1),
                       done: (r == H-1 && c == W-1)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge writeClk); #1;
      pixelValid = 0; frameStart = 0; pixelIn = PW'($urandom);
    end
  endtask

  task automatic sendFrame(input bit fs, input bit gaps, input int lastR, input int lastC);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r*W + c > lastR*W + lastC) return;
        if (gaps) idle($urandom_range(0, 1));
        sendPixel(r, c, fs && r == 0 && c == 0);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN = 0; locked = 0; pixelValid = 0; frameStart = 0; pixelIn = '0;
    repeat (3) @(posedge writeClk);
    #1;
    resetN = 1; locked = 1; monEn = 1; expectZero = 1;
    idle(2);
    sendFrame(1, 0, H-1, W-1);                 // continuous frame
    sendFrame(1, 0, H-1, W-1);                 // back-to-back frame
    idle(3);
    sendFrame(1, 1, H-1, W-1);                 // random valid gaps
    sendFrame(1, 0, 3, 3);                     // abandoned at (3,4)
    sendFrame(1, 0, H-1, W-1);
    sendFrame(1, 1, 3, 3);                     // lock loss mid-line
    repeat (5) begin
      @(posedge writeClk); #1;
      locked = 0; pixelValid = 1; frameStart = 0; pixelIn = PW'($urandom);
    end
    sendFrame(0, 0, H-1, W-1);                 // relock: counters must restart at (0,0)
    sendFrame(1, 0, 2, 5);                     // reset mid-frame
    @(posedge writeClk); #1;
    resetN = 0; pixelValid = 1; frameStart = 0; pixelIn = 8'h55;
    @(posedge writeClk); #1;
    resetN = 1; pixelValid = 0; expectZero = 1;
    sendFrame(0, 0, H-1, W-1);
    idle(2);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge writeClk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d windows pending expected 0", expQ.size());
    end
    @(negedge writeClk);
    monEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
